// File: rtl/ssemi_adc_decimator_mc_merge_pkg.sv
// rtl/ssemi_adc_decimator_mc_merge_pkg.sv - shared constants for the multi-channel decimator merge
// Purpose: default channel count, FIFO depth and CSR address field layout.
// Ports: none (package).
package ssemi_adc_decimator_mc_merge_pkg;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_FIFO_DEPTH = 4;

  // Core register address occupies [7:0]; channel select starts right above it.
  localparam int CSR_REG_W      = 8;
  localparam int CSR_CH_SEL_LSB = 8;

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/ssemi_adc_decimator_ch_fifo.sv
// rtl/ssemi_adc_decimator_ch_fifo.sv - per-channel synchronous sample FIFO
// Purpose: buffers one channel's decimated samples.
// Ports: i_clk/i_rst clock and sync active-high reset; i_push/i_push_data write side;
//        i_pop/o_pop_data read side (data valid whenever !o_empty); o_full/o_empty status.
module ssemi_adc_decimator_ch_fifo
  import ssemi_adc_decimator_mc_merge_pkg::*;
#(
  parameter int DW    = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_pop_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push    = i_push && !o_full;
  assign do_pop     = i_pop && !o_empty;
  // Status comes only from the registered count, so ready never depends on the pop side.
  assign o_full     = (count == (AW+1)'(DEPTH));
  assign o_empty    = (count == '0);
  assign o_pop_data = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ssemi_adc_decimator_mc_merge.sv
// rtl/ssemi_adc_decimator_mc_merge.sv - round-robin merge of per-channel decimator streams
// Purpose: per-channel FIFOs merged round-robin into one channel-tagged stream, CSR fan-out
//          to the addressed core, sticky maskable per-channel error status.
// Ports: i_ch_valid/i_ch_data/o_ch_ready per-channel input streams;
//        o_decim_valid/o_decim_data/o_decim_ch/i_decim_ready merged output;
//        i_csr_* / o_csr_* host CSR bus; o_ch_csr_* / i_ch_csr_* per-core CSR buses;
//        o_csr_addr_err out-of-range access pulse; i_ch_error/i_err_mask/i_err_clr,
//        o_err_status/o_error error aggregation.
module ssemi_adc_decimator_mc_merge
  import ssemi_adc_decimator_mc_merge_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int CH_W      = ch_idx_w(NUM_CH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_CH-1:0]            i_ch_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_ch_data,
  output logic [NUM_CH-1:0]            o_ch_ready,
  output logic                         o_decim_valid,
  output logic [DATA_WIDTH-1:0]        o_decim_data,
  output logic [CH_W-1:0]              o_decim_ch,
  input  logic                         i_decim_ready,
  input  logic                         i_csr_wr_valid,
  input  logic [CSR_CH_SEL_LSB+CH_W-1:0] i_csr_addr,
  input  logic [31:0]                  i_csr_wr_data,
  output logic                         o_csr_wr_ready,
  input  logic                         i_csr_rd_ready,
  output logic [31:0]                  o_csr_rd_data,
  output logic [NUM_CH-1:0]            o_ch_csr_wr_valid,
  output logic [CSR_REG_W-1:0]         o_ch_csr_addr,
  output logic [31:0]                  o_ch_csr_wr_data,
  input  logic [NUM_CH-1:0]            i_ch_csr_wr_ready,
  output logic [NUM_CH-1:0]            o_ch_csr_rd_ready,
  input  logic [NUM_CH*32-1:0]         i_ch_csr_rd_data,
  output logic                         o_csr_addr_err,
  input  logic [NUM_CH-1:0]            i_ch_error,
  input  logic [NUM_CH-1:0]            i_err_mask,
  input  logic [NUM_CH-1:0]            i_err_clr,
  output logic [NUM_CH-1:0]            o_err_status,
  output logic                         o_error
);

  logic [NUM_CH-1:0]     fifo_full;
  logic [NUM_CH-1:0]     fifo_empty;
  logic [NUM_CH-1:0]     fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_data [NUM_CH];

  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] grant;
  logic [CH_W:0]   scan_idx;
  logic            grant_vld;
  logic            load;
  logic            fire;

  logic [CH_W-1:0] csr_sel;
  logic            sel_ok;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_fifo
      ssemi_adc_decimator_ch_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (i_ch_valid[g] & ~fifo_full[g]),
        .i_push_data (i_ch_data[g*DATA_WIDTH +: DATA_WIDTH]),
        .i_pop       (fifo_pop[g]),
        .o_pop_data  (fifo_data[g]),
        .o_full      (fifo_full[g]),
        .o_empty     (fifo_empty[g])
      );
    end
  endgenerate

  assign o_ch_ready = ~fifo_full;

  // Scan channels starting at the RR pointer, wrapping once; first non-empty wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (scan_idx >= (CH_W+1)'(NUM_CH)) scan_idx = scan_idx - (CH_W+1)'(NUM_CH);
      if (!grant_vld && !fifo_empty[scan_idx[CH_W-1:0]]) begin
        grant     = scan_idx[CH_W-1:0];
        grant_vld = 1'b1;
      end
    end
  end

  assign load     = !o_decim_valid || i_decim_ready;
  assign fire     = load && grant_vld;
  assign fifo_pop = fire ? (NUM_CH'(1) << grant) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_decim_valid <= 1'b0;
      o_decim_data  <= '0;
      o_decim_ch    <= '0;
      rr_ptr        <= '0;
    end else if (load) begin
      o_decim_valid <= grant_vld;
      if (grant_vld) begin
        o_decim_data <= fifo_data[grant];
        o_decim_ch   <= grant;
        rr_ptr       <= (grant == CH_W'(NUM_CH-1)) ? '0 : grant + CH_W'(1);
      end
    end
  end

  assign csr_sel          = i_csr_addr[CSR_CH_SEL_LSB +: CH_W];
  assign o_ch_csr_addr    = i_csr_addr[CSR_REG_W-1:0];
  assign o_ch_csr_wr_data = i_csr_wr_data;

  // Unmatched select leaves every core idle and acks writes so the host never stalls.
  always_comb begin
    sel_ok            = 1'b0;
    o_ch_csr_wr_valid = '0;
    o_ch_csr_rd_ready = '0;
    o_csr_wr_ready    = 1'b1;
    o_csr_rd_data     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (csr_sel == CH_W'(c)) begin
        sel_ok               = 1'b1;
        o_ch_csr_wr_valid[c] = i_csr_wr_valid;
        o_ch_csr_rd_ready[c] = i_csr_rd_ready;
        o_csr_wr_ready       = i_ch_csr_wr_ready[c];
        o_csr_rd_data        = i_ch_csr_rd_data[c*32 +: 32];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err_status   <= '0;
      o_error        <= 1'b0;
      o_csr_addr_err <= 1'b0;
    end else begin
      // Set is OR-ed in after the clear so a same-cycle event is never lost.
      o_err_status   <= (o_err_status & ~i_err_clr) | i_ch_error;
      o_error        <= |(o_err_status & ~i_err_mask);
      o_csr_addr_err <= !sel_ok && (i_csr_wr_valid || i_csr_rd_ready);
    end
  end

endmodule

// File: tb/tb_ssemi_adc_decimator_mc_merge.sv
// tb/tb_ssemi_adc_decimator_mc_merge.sv - directed self-checking bench for the channel merge
module tb_ssemi_adc_decimator_mc_merge;

  localparam int NC = 4;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NC-1:0]    ch_valid = '0;
  logic [NC*DW-1:0] ch_data = '0;
  logic [NC-1:0]    ch_ready;
  logic             decim_valid;
  logic [DW-1:0]    decim_data;
  logic [1:0]       decim_ch;
  logic             decim_ready = 1'b1;
  logic             csr_wr_valid = 1'b0;
  logic [9:0]       csr_addr = '0;
  logic [31:0]      csr_wr_data = '0;
  logic             csr_wr_ready;
  logic             csr_rd_ready = 1'b0;
  logic [31:0]      csr_rd_data;
  logic [NC-1:0]    ch_csr_wr_valid;
  logic [7:0]       ch_csr_addr;
  logic [31:0]      ch_csr_wr_data;
  logic [NC-1:0]    ch_csr_wr_ready = '1;
  logic [NC-1:0]    ch_csr_rd_ready;
  logic [NC*32-1:0] ch_csr_rd_data = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
  logic             csr_addr_err;
  logic [NC-1:0]    ch_error = '0;
  logic [NC-1:0]    err_mask = '0;
  logic [NC-1:0]    err_clr = '0;
  logic [NC-1:0]    err_status;
  logic             error;

  // Three-channel instance: with four channels the 2-bit select can never be out of range.
  logic [9:0]  c3_csr_addr = '0;
  logic [2:0]  c3_ch_ready;
  logic        c3_decim_valid;
  logic [DW-1:0] c3_decim_data;
  logic [1:0]  c3_decim_ch;
  logic        c3_csr_wr_ready;
  logic [31:0] c3_csr_rd_data;
  logic [2:0]  c3_ch_csr_wr_valid;
  logic [7:0]  c3_ch_csr_addr;
  logic [31:0] c3_ch_csr_wr_data;
  logic [2:0]  c3_ch_csr_rd_ready;
  logic        c3_csr_addr_err;
  logic [2:0]  c3_err_status;
  logic        c3_error;

  ssemi_adc_decimator_mc_merge #(.NUM_CH(NC), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_ch_valid(ch_valid), .i_ch_data(ch_data), .o_ch_ready(ch_ready),
    .o_decim_valid(decim_valid), .o_decim_data(decim_data), .o_decim_ch(decim_ch),
    .i_decim_ready(decim_ready),
    .i_csr_wr_valid(csr_wr_valid), .i_csr_addr(csr_addr), .i_csr_wr_data(csr_wr_data),
    .o_csr_wr_ready(csr_wr_ready), .i_csr_rd_ready(csr_rd_ready), .o_csr_rd_data(csr_rd_data),
    .o_ch_csr_wr_valid(ch_csr_wr_valid), .o_ch_csr_addr(ch_csr_addr),
    .o_ch_csr_wr_data(ch_csr_wr_data), .i_ch_csr_wr_ready(ch_csr_wr_ready),
    .o_ch_csr_rd_ready(ch_csr_rd_ready), .i_ch_csr_rd_data(ch_csr_rd_data),
    .o_csr_addr_err(csr_addr_err),
    .i_ch_error(ch_error), .i_err_mask(err_mask), .i_err_clr(err_clr),
    .o_err_status(err_status), .o_error(error)
  );

  ssemi_adc_decimator_mc_merge #(.NUM_CH(3), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) u_dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_ch_valid(3'b000), .i_ch_data({(3*DW){1'b0}}), .o_ch_ready(c3_ch_ready),
    .o_decim_valid(c3_decim_valid), .o_decim_data(c3_decim_data), .o_decim_ch(c3_decim_ch),
    .i_decim_ready(1'b1),
    .i_csr_wr_valid(csr_wr_valid), .i_csr_addr(c3_csr_addr), .i_csr_wr_data(csr_wr_data),
    .o_csr_wr_ready(c3_csr_wr_ready), .i_csr_rd_ready(csr_rd_ready),
    .o_csr_rd_data(c3_csr_rd_data),
    .o_ch_csr_wr_valid(c3_ch_csr_wr_valid), .o_ch_csr_addr(c3_ch_csr_addr),
    .o_ch_csr_wr_data(c3_ch_csr_wr_data), .i_ch_csr_wr_ready(3'b000),
    .o_ch_csr_rd_ready(c3_ch_csr_rd_ready),
    .i_ch_csr_rd_data({32'h33333333, 32'h22222222, 32'h11111111}),
    .o_csr_addr_err(c3_csr_addr_err),
    .i_ch_error(3'b000), .i_err_mask(3'b000), .i_err_clr(3'b000),
    .o_err_status(c3_err_status), .o_error(c3_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output scoreboard: every accepted merged beat, with the cycle it was accepted in.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] q_data [$];
  logic [1:0]    q_ch [$];
  int            q_cyc [$];

  always @(negedge clk) begin
    if (!rst && decim_valid && decim_ready) begin
      q_data.push_back(decim_data);
      q_ch.push_back(decim_ch);
      q_cyc.push_back(cyc);
    end
  end

  int cnt [NC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_ch.delete();
    q_cyc.delete();
    for (int c = 0; c < NC; c++) cnt[c] = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    ch_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Channel c sends (c+1)*0x100 + n for its n-th accepted sample.
  task automatic stream(input logic [NC-1:0] vmask, input int ncyc);
    logic [NC-1:0] acc;
    for (int k = 0; k < ncyc; k++) begin
      for (int c = 0; c < NC; c++) ch_data[c*DW +: DW] = DW'((c + 1) * 256 + cnt[c]);
      ch_valid = vmask;
      acc = ch_ready & vmask;
      tick();
      for (int c = 0; c < NC; c++) if (acc[c]) cnt[c]++;
    end
    ch_valid = '0;
  endtask

  initial begin
    // 1: reset with busy inputs
    rst = 1'b1;
    ch_valid = 4'hF;
    ch_data = {NC*DW{1'b1}};
    repeat (3) tick();
    check("rst_valid", decim_valid, 0);
    check("rst_data", decim_data, 0);
    check("rst_ch", decim_ch, 0);
    check("rst_status", err_status, 0);
    check("rst_error", error, 0);
    check("rst_addr_err", csr_addr_err, 0);
    rst = 1'b0;
    ch_valid = '0;
    tick();
    check("rst_ready_after", ch_ready, 4'hF);
    check("rst_valid_after", decim_valid, 0);

    // 2: single channel, latency and order
    clear_q();
    ch_data[2*DW +: DW] = 24'h000001;
    ch_valid = 4'b0100;
    tick();
    check("t2_lat_first_edge", decim_valid, 0);
    ch_data[2*DW +: DW] = 24'h000002;
    tick();
    check("t2_lat_valid", decim_valid, 1);
    check("t2_lat_data", decim_data, 24'h000001);
    check("t2_lat_ch", decim_ch, 2);
    for (int k = 3; k <= 8; k++) begin
      ch_data[2*DW +: DW] = DW'(k);
      tick();
    end
    ch_valid = '0;
    repeat (6) tick();
    check("t2_count", q_data.size(), 8);
    for (int i = 0; i < 8 && i < q_data.size(); i++) begin
      check($sformatf("t2_data%0d", i), q_data[i], i + 1);
      check($sformatf("t2_ch%0d", i), q_ch[i], 2);
    end

    // 3: fairness, all channels streaming
    reset_dut();
    clear_q();
    stream(4'hF, 16);
    repeat (24) tick();
    check("t3_total", q_data.size(), cnt[0] + cnt[1] + cnt[2] + cnt[3]);
    for (int i = 0; i < 12 && i + 1 < q_data.size(); i++) begin
      check($sformatf("t3_ch%0d", i), q_ch[i], i % 4);
      check($sformatf("t3_data%0d", i), q_data[i], (i % 4 + 1) * 256 + i / 4);
      if (i < 11) check($sformatf("t3_gap%0d", i), q_cyc[i+1] - q_cyc[i], 1);
    end

    // 4: backpressure on ch0
    reset_dut();
    clear_q();
    decim_ready = 1'b0;
    stream(4'b0001, 10);
    check("t4_accepted", cnt[0], 5);
    check("t4_ready_low", ch_ready[0], 0);
    check("t4_held_valid", decim_valid, 1);
    check("t4_held_data", decim_data, 24'h000100);
    check("t4_held_ch", decim_ch, 0);
    decim_ready = 1'b1;
    repeat (8) tick();
    check("t4_count", q_data.size(), 5);
    for (int i = 0; i < 5 && i < q_data.size(); i++)
      check($sformatf("t4_data%0d", i), q_data[i], 256 + i);
    check("t4_ready_back", ch_ready[0], 1);

    // 5: CSR fan-out and out-of-range select
    csr_addr = 10'h305;
    csr_wr_valid = 1'b1;
    csr_wr_data = 32'h0000A5A5;
    ch_csr_wr_ready = 4'b0111;
    #1;
    check("t5_wr_onehot", ch_csr_wr_valid, 4'b1000);
    check("t5_addr", ch_csr_addr, 8'h05);
    check("t5_wr_data", ch_csr_wr_data, 32'h0000A5A5);
    check("t5_wr_ready_sel", csr_wr_ready, 0);
    check("t5_rd_idle", ch_csr_rd_ready, 0);
    ch_csr_wr_ready = 4'b1000;
    #1;
    check("t5_wr_ready_sel1", csr_wr_ready, 1);
    tick();
    check("t5_no_addr_err", csr_addr_err, 0);
    csr_wr_valid = 1'b0;
    csr_addr = 10'h120;
    csr_rd_ready = 1'b1;
    c3_csr_addr = 10'h3AB;
    #1;
    check("t5_rd_onehot", ch_csr_rd_ready, 4'b0010);
    check("t5_rd_data", csr_rd_data, 32'hBBBB0001);
    check("t5_oor_rd_data", c3_csr_rd_data, 0);
    check("t5_oor_rd_strobe", c3_ch_csr_rd_ready, 0);
    check("t5_oor_wr_ready", c3_csr_wr_ready, 1);
    check("t5_oor_err_pre", c3_csr_addr_err, 0);
    tick();
    csr_rd_ready = 1'b0;
    check("t5_oor_err_pulse", c3_csr_addr_err, 1);
    tick();
    check("t5_oor_err_clear", c3_csr_addr_err, 0);
    c3_csr_addr = '0;

    // 6: sticky errors, set-wins, masking
    ch_error = 4'b0010;
    err_clr = 4'b0010;
    tick();
    ch_error = '0;
    err_clr = '0;
    check("t6_set_wins", err_status, 4'b0010);
    check("t6_error_lag", error, 0);
    tick();
    check("t6_error_set", error, 1);
    err_mask = 4'b0010;
    tick();
    check("t6_masked_error", error, 0);
    check("t6_mask_keeps", err_status, 4'b0010);
    err_clr = 4'b0010;
    tick();
    err_clr = '0;
    check("t6_cleared", err_status, 0);
    err_mask = '0;
    repeat (2) tick();
    check("t6_unmask_error", error, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
